// File: rtl/capture_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : capture_scheduler_if                                          |
// | Brief    : Capture/analysis handshake and sample-RAM ownership bundle.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface capture_scheduler_if;
   logic cap_req;
   logic cap_done;
   logic ana_start;
   logic ana_done;
   logic buf_owner;

   modport master (
      output cap_req,
      output ana_start,
      output buf_owner,
      input  cap_done,
      input  ana_done
   );

   modport slave (
      input  cap_req,
      input  ana_start,
      input  buf_owner,
      output cap_done,
      output ana_done
   );
endinterface
`default_nettype wire

// File: rtl/capture_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : capture_scheduler                                             |
// | Brief    : Frame sequencer: capture, analysis, hold-off, with timeouts.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module capture_scheduler #(
   parameter int CAP_TIMEOUT = 120_000_000,
   parameter int ANA_TIMEOUT = 4_000_000,
   parameter int HOLDOFF     = 10_000_000,
   parameter int TW          = 28
) (
   input  logic                       clk_100,
   input  logic                       rst_n,
   input  logic                       enable,
   input  logic                       single,
   input  logic                       err_clr,
   capture_scheduler_if.master        hs,
   output logic                       busy,
   output logic                       frame_done,
   output logic [15:0]                frame_cnt,
   output logic                       err,
   output logic [1:0]                 err_code
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_CAP  = 3'd1;
   localparam logic [2:0] S_ANA  = 3'd2;
   localparam logic [2:0] S_HOLD = 3'd3;
   localparam logic [2:0] S_ERR  = 3'd4;

   localparam logic [TW-1:0] c_cap_last  = TW'(CAP_TIMEOUT - 1);
   localparam logic [TW-1:0] c_ana_last  = TW'(ANA_TIMEOUT - 1);
   localparam logic [TW-1:0] c_hold_last = TW'(HOLDOFF - 1);
   localparam logic [TW-1:0] c_cnt_max   = '1;
   localparam logic [TW-1:0] c_cnt_one   = TW'(1);

   logic [2:0]    r_state;
   logic [2:0]    w_next;
   logic [TW-1:0] r_cnt;
   logic          r_one_frame;
   logic          r_cap_req;
   logic          r_ana_start;
   logic          r_buf_owner;
   logic          r_busy;
   logic          r_frame_done;
   logic [15:0]   r_frame_cnt;
   logic          r_err;
   logic [1:0]    r_err_code;

   logic          w_one_frame;
   logic          w_cap_req;
   logic          w_ana_start;
   logic          w_buf_owner;
   logic          w_busy;
   logic          w_frame_done;
   logic [15:0]   w_frame_cnt;
   logic          w_err;
   logic [1:0]    w_err_code;
   logic          w_cap_last;
   logic          w_ana_last;
   logic          w_hold_last;

   assign w_cap_last  = (r_cnt == c_cap_last);
   assign w_ana_last  = (r_cnt == c_ana_last);
   assign w_hold_last = (r_cnt == c_hold_last);

   always_ff @(posedge clk_100 or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // A done pulse on the same edge as the timeout wins over the timeout.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (enable || single) w_next = S_CAP;
         end
         S_CAP: begin
            if (hs.cap_done)     w_next = S_ANA;
            else if (w_cap_last) w_next = S_ERR;
         end
         S_ANA: begin
            if (hs.ana_done)     w_next = (enable && !r_one_frame) ? S_HOLD : S_IDLE;
            else if (w_ana_last) w_next = S_ERR;
         end
         S_HOLD: begin
            if (!enable)          w_next = S_IDLE;
            else if (w_hold_last) w_next = S_CAP;
         end
         S_ERR: begin
            if (err_clr) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so that every port is registered
   // yet changes on the same edge as the state itself.
   always_comb begin
      w_cap_req    = (w_next == S_CAP);
      w_ana_start  = (r_state == S_CAP) && (w_next == S_ANA);
      w_buf_owner  = (w_next == S_ANA);
      w_busy       = (w_next != S_IDLE) && (w_next != S_ERR);
      w_frame_done = (r_state == S_ANA) && hs.ana_done;
      w_frame_cnt  = r_frame_cnt + {15'd0, w_frame_done};
      w_err        = (w_next == S_ERR);
      w_err_code   = r_err_code;
      if (w_next != S_ERR)       w_err_code = 2'b00;
      else if (r_state == S_CAP) w_err_code = 2'b01;
      else if (r_state == S_ANA) w_err_code = 2'b10;
      w_one_frame  = r_one_frame;
      if ((r_state == S_IDLE) && single) w_one_frame = 1'b1;
      else if (w_next == S_IDLE)         w_one_frame = 1'b0;
   end

   always_ff @(posedge clk_100 or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt        <= '0;
         r_one_frame  <= 1'b0;
         r_cap_req    <= 1'b0;
         r_ana_start  <= 1'b0;
         r_buf_owner  <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_frame_cnt  <= 16'd0;
         r_err        <= 1'b0;
         r_err_code   <= 2'b00;
      end else begin
         if (w_next != r_state)     r_cnt <= '0;
         else if (r_cnt != c_cnt_max) r_cnt <= r_cnt + c_cnt_one;
         r_one_frame  <= w_one_frame;
         r_cap_req    <= w_cap_req;
         r_ana_start  <= w_ana_start;
         r_buf_owner  <= w_buf_owner;
         r_busy       <= w_busy;
         r_frame_done <= w_frame_done;
         r_frame_cnt  <= w_frame_cnt;
         r_err        <= w_err;
         r_err_code   <= w_err_code;
      end
   end

   assign hs.cap_req   = r_cap_req;
   assign hs.ana_start = r_ana_start;
   assign hs.buf_owner = r_buf_owner;
   assign busy         = r_busy;
   assign frame_done   = r_frame_done;
   assign frame_cnt    = r_frame_cnt;
   assign err          = r_err;
   assign err_code     = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_capture_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_capture_scheduler                                          |
// | Brief    : Directed self-checking bench with capture/analysis peer models.|
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_capture_scheduler;

   typedef struct {
      int         cap_lat;   // 0 = peer never answers
      int         ana_lat;
      int         exp_cap;   // cycles cap_req is high
      int         exp_own;   // cycles buf_owner is high
      int         exp_start; // ana_start pulses
      int         exp_fd;    // frame_done pulses
      logic       exp_err;
      logic [1:0] exp_code;
   } vec_t;

   logic        clk_100 = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        single;
   logic        err_clr;
   logic        busy;
   logic        frame_done;
   logic [15:0] frame_cnt;
   logic        err;
   logic [1:0]  err_code;

   logic        model_cap_done = 1'b0;
   logic        spur_cap_done  = 1'b0;
   logic        model_ana_done = 1'b0;
   int          cap_lat = 0;
   int          ana_lat = 0;
   int          cap_age = 0;
   int          ana_age = 0;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] exp_cnt  = 16'd0;
   vec_t        vecs[6];

   capture_scheduler_if hs();

   assign hs.cap_done = model_cap_done | spur_cap_done;
   assign hs.ana_done = model_ana_done;

   capture_scheduler #(
      .CAP_TIMEOUT(200),
      .ANA_TIMEOUT(30),
      .HOLDOFF    (100),
      .TW         (28)
   ) dut (
      .clk_100   (clk_100),
      .rst_n     (rst_n),
      .enable    (enable),
      .single    (single),
      .err_clr   (err_clr),
      .hs        (hs),
      .busy      (busy),
      .frame_done(frame_done),
      .frame_cnt (frame_cnt),
      .err       (err),
      .err_code  (err_code)
   );

   always #5 clk_100 = ~clk_100;

   // Peer models: answer cap_lat cycles after cap_req rises, ana_lat after ana_start.
   always @(posedge clk_100) begin
      #1;
      model_cap_done = 1'b0;
      if (hs.cap_req && cap_lat != 0) begin
         cap_age++;
         if (cap_age == cap_lat) model_cap_done = 1'b1;
      end else begin
         cap_age = 0;
      end
      model_ana_done = 1'b0;
      if (!hs.buf_owner)    ana_age = 0;
      else if (hs.ana_start) ana_age = 1;
      else if (ana_age != 0) ana_age++;
      if (ana_age != 0 && ana_lat != 0 && ana_age == ana_lat) begin
         model_ana_done = 1'b1;
         ana_age        = 0;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int ncap   = 0;
      int nown   = 0;
      int nstart = 0;
      int nfd    = 0;
      int guard  = 0;
      int nlate  = 0;
      cap_lat = v.cap_lat;
      ana_lat = v.ana_lat;
      @(negedge clk_100); single = 1'b1;
      @(negedge clk_100); single = 1'b0;
      while (guard < 1000) begin
         if (hs.cap_req)   ncap++;
         if (hs.buf_owner) nown++;
         if (hs.ana_start) nstart++;
         if (frame_done)   nfd++;
         if (!busy) break;
         @(negedge clk_100);
         guard++;
      end
      exp_cnt = exp_cnt + 16'(v.exp_fd);
      check($sformatf("v%0d_bound", idx), 32'(guard < 1000), 32'd1);
      check($sformatf("v%0d_cap_cycles", idx), ncap, v.exp_cap);
      check($sformatf("v%0d_own_cycles", idx), nown, v.exp_own);
      check($sformatf("v%0d_ana_start", idx), nstart, v.exp_start);
      check($sformatf("v%0d_frame_done", idx), nfd, v.exp_fd);
      check($sformatf("v%0d_err", idx), err, v.exp_err);
      check($sformatf("v%0d_err_code", idx), err_code, v.exp_code);
      check($sformatf("v%0d_frame_cnt", idx), frame_cnt, exp_cnt);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk_100);
         if (hs.cap_req) nlate++;
      end
      check($sformatf("v%0d_no_more_req", idx), nlate, 0);
      if (v.exp_err) begin
         spur_cap_done = 1'b1; single = 1'b1; enable = 1'b1;
         @(negedge clk_100);
         spur_cap_done = 1'b0; single = 1'b0; enable = 1'b0;
         @(negedge clk_100);
         check($sformatf("v%0d_err_hold", idx), {busy, err, err_code, hs.cap_req, hs.ana_start, hs.buf_owner},
               {1'b0, 1'b1, v.exp_code, 3'b000});
         err_clr = 1'b1;
         @(negedge clk_100);
         err_clr = 1'b0;
         check($sformatf("v%0d_err_clr", idx), {busy, err, err_code}, 4'b0000);
      end
   endtask

   initial begin
      int t, t_fd1, t_rise2, nrise, nfd, ncap1, nown1, nstart_ok, nlate, guard;
      logic prev_cap;

      vecs[0] = '{50,  20, 50,  20, 1, 1, 1'b0, 2'b00};
      vecs[1] = '{1,   1,  1,   1,  1, 1, 1'b0, 2'b00};
      vecs[2] = '{0,   20, 200, 0,  0, 0, 1'b1, 2'b01};
      vecs[3] = '{10,  0,  10,  30, 1, 0, 1'b1, 2'b10};
      vecs[4] = '{200, 30, 200, 30, 1, 1, 1'b0, 2'b00};
      vecs[5] = '{201, 20, 200, 0,  0, 0, 1'b1, 2'b01};

      rst_n = 1'b0; enable = 1'b0; single = 1'b0; err_clr = 1'b0;
      repeat (3) @(negedge clk_100);
      check("reset_outputs", {hs.cap_req, hs.ana_start, hs.buf_owner, busy, frame_done, err, err_code}, 8'h00);
      check("reset_frame_cnt", frame_cnt, 16'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk_100);
      check("idle_stays_idle", {busy, hs.cap_req}, 2'b00);

      for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

      // Continuous mode: two frames with hold-off between them.
      cap_lat = 50; ana_lat = 20;
      t = 0; t_fd1 = 0; t_rise2 = 0; nrise = 0; nfd = 0; ncap1 = 0; nown1 = 0; nstart_ok = 0;
      prev_cap = 1'b0;
      @(negedge clk_100); enable = 1'b1;
      while (t < 2000) begin
         @(negedge clk_100);
         t++;
         if (hs.cap_req && !prev_cap) begin
            nrise++;
            if (nrise == 2) t_rise2 = t;
         end
         if (hs.cap_req && nrise == 1) ncap1++;
         if (hs.buf_owner && nfd == 0) nown1++;
         if (hs.ana_start && !hs.cap_req && prev_cap && hs.buf_owner) nstart_ok++;
         if (frame_done) begin
            nfd++;
            if (nfd == 1) t_fd1 = t;
         end
         prev_cap = hs.cap_req;
         if (nfd == 2) break;
      end
      enable = 1'b0;
      exp_cnt = exp_cnt + 16'd2;
      check("cont_frames", nfd, 2);
      check("cont_cap_cycles", ncap1, 50);
      check("cont_own_cycles", nown1, 20);
      check("cont_start_on_done_edge", nstart_ok, 2);
      check("cont_holdoff", t_rise2 - t_fd1, 100);
      check("cont_frame_cnt", frame_cnt, exp_cnt);
      guard = 0;
      while (busy && guard < 200) begin @(negedge clk_100); guard++; end
      check("cont_to_idle", busy, 1'b0);

      // enable falls during analysis: frame finishes, hold-off skipped.
      cap_lat = 10; ana_lat = 20;
      @(negedge clk_100); enable = 1'b1;
      guard = 0;
      while (!hs.buf_owner && guard < 100) begin @(negedge clk_100); guard++; end
      enable = 1'b0;
      guard = 0;
      while (!frame_done && guard < 100) begin @(negedge clk_100); guard++; end
      exp_cnt = exp_cnt + 16'd1;
      check("drop_frame_done", frame_done, 1'b1);
      check("drop_busy", busy, 1'b0);
      check("drop_frame_cnt", frame_cnt, exp_cnt);
      nlate = 0;
      for (int k = 0; k < 120; k++) begin
         @(negedge clk_100);
         if (hs.cap_req) nlate++;
      end
      check("drop_no_hold_req", nlate, 0);

      // Asynchronous reset in the middle of analysis.
      @(negedge clk_100); enable = 1'b1;
      guard = 0;
      while (!hs.buf_owner && guard < 100) begin @(negedge clk_100); guard++; end
      repeat (3) @(negedge clk_100);
      #2 rst_n = 1'b0;
      #1;
      check("arst_outputs", {hs.cap_req, hs.ana_start, hs.buf_owner, busy, frame_done, err, err_code}, 8'h00);
      check("arst_frame_cnt", frame_cnt, 16'd0);
      exp_cnt = 16'd0;
      @(negedge clk_100); enable = 1'b0;
      @(negedge clk_100); rst_n = 1'b1;
      nfd = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk_100);
         if (frame_done) nfd++;
      end
      check("arst_no_frame_done", nfd, 0);

      // frame_cnt wrap.
      @(negedge clk_100); force dut.r_frame_cnt = 16'hFFFF;
      @(negedge clk_100); release dut.r_frame_cnt;
      exp_cnt = 16'hFFFF;
      @(negedge clk_100);
      check("wrap_preset", frame_cnt, exp_cnt);
      run_vec(vecs[0], 6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
